// File: rtl/fetch_pkg.sv
// Shared types and constants for the IFU->IDU fetch queue.
package fetch_pkg;

  localparam int unsigned FQ_DEPTH  = 4;
  localparam int unsigned FQ_PC_W   = 64;
  localparam int unsigned FQ_INST_W = 32;

  localparam logic [FQ_PC_W-1:0]   RESET_PC = 64'h8000_0000;
  localparam logic [FQ_INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [FQ_PC_W-1:0]   pc;
    logic [FQ_INST_W-1:0] inst;
    logic                 misal;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo_ptr.sv
// FIFO pointer with an extra wrap bit above the index bits.
// Supports a synchronous clear and a single-step increment.
module fifo_ptr #(
  parameter int unsigned AW = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [AW:0] ptr_o
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] ptr_q, ptr_d;

  // The binary carry out of the index bits toggles the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i)
      ptr_d = '0;
    else if (inc_i)
      ptr_d = ptr_q + PTR_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: in-order {pc, inst} queue
// with valid/ready on both sides and a synchronous redirect flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned PC_W   = FQ_PC_W,
  parameter int unsigned INST_W = FQ_INST_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic                     out_misal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              misal;
  } entry_t;

  logic [AW:0] rd_ptr, wr_ptr;
  logic        empty, full, push, pop;
  entry_t      mem [DEPTH];
  entry_t      head;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

  // in_ready depends only on registered pointers, so out_ready never reaches it.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush),
    .inc_i   (push),
    .ptr_o   (wr_ptr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush),
    .inc_i   (pop),
    .ptr_o   (rd_ptr)
  );

  // Storage is not reset; out_valid gating hides stale contents.
  always_ff @(posedge clock) begin
    if (push && !reset)
      mem[wr_ptr[AW-1:0]] <= '{pc: in_pc, inst: in_inst, misal: |in_pc[1:0]};
  end

  assign head = mem[rd_ptr[AW-1:0]];

  always_comb begin
    out_pc    = '0;
    out_inst  = '0;
    out_misal = 1'b0;
    if (!empty) begin
      out_pc    = head.pc;
      out_inst  = head.inst;
      out_misal = head.misal;
    end
  end

  assign count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed scoreboard bench for fetch_queue.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misal;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(64), .INST_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_misal (out_misal),
    .count     (count)
  );

  always #5 clock = ~clock;

  fetch_entry_t exp_q[$];
  int occ_now = 0;
  int occ_next = 0;
  bit started = 0;
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Model: occupancy plus an ordered list of accepted entries.
  task automatic step(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl, input logic rst);
    bit acc, pp;
    fetch_entry_t e;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    acc = iv && !fl && !rst && (occ_now < DEPTH);
    pp  = ordy && !fl && !rst && (occ_now > 0);
    if (acc) begin
      e.pc = pc;
      e.inst = inst;
      e.misal = (pc % 4) != 0;
      exp_q.push_back(e);
    end
    occ_next = (fl || rst) ? 0 : occ_now + int'(acc) - int'(pp);
    @(posedge clock);
    #1;
    occ_now = occ_next;
  endtask

  // Monitor: compares DUT state and head against the scoreboard each cycle.
  always @(negedge clock) begin
    if (started) begin
      chk("count", 64'(count), 64'(occ_now));
      chk("in_ready", 64'(in_ready), 64'(occ_now < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(occ_now > 0));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("head_present", 64'(0), 64'(1));
        end else begin
          chk("out_pc", out_pc, exp_q[0].pc);
          chk("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
          chk("out_misal", 64'(out_misal), 64'(exp_q[0].misal));
          if (out_ready && !flush && !reset)
            void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_pc", out_pc, 64'h0);
        chk("idle_inst", 64'(out_inst), 64'h0);
        chk("idle_misal", 64'(out_misal), 64'h0);
      end
      if (flush || reset)
        exp_q.delete();
    end
  end

  initial begin
    logic [63:0] pc;
    step(0, '0, '0, 0, 0, 1);
    step(0, '0, '0, 0, 0, 1);
    started = 1;
    // Reset state, then a single push becomes visible next cycle.
    step(0, '0, '0, 0, 0, 0);
    step(1, RESET_PC, INST_NOP, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    step(0, '0, '0, 0, 0, 0);
    // Fill to full with decode stalled; fifth push must be dropped.
    for (int i = 0; i < 5; i++)
      step(1, RESET_PC + 64'(4 * i), 32'h100 + 32'(i), 0, 0, 0);
    step(1, 64'h8000_0040, 32'hBAD, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, '0, '0, 1, 0, 0);
    // Streaming through several pointer wraps.
    for (int i = 0; i < 21; i++)
      step(1, RESET_PC + 64'(4 * i), 32'h200 + 32'(i), 1, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    // Flush with three queued and a same-cycle push.
    for (int i = 0; i < 3; i++)
      step(1, 64'h8000_0020 + 64'(4 * i), 32'h300 + 32'(i), 0, 0, 0);
    step(1, 64'h8000_00F0, 32'hDEAD, 1, 1, 0);
    step(1, 64'h8000_0100, 32'h400, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    // Misaligned flag is captured with the entry.
    step(1, 64'h8000_0002, 32'h500, 0, 0, 0);
    step(1, 64'h8000_0004, 32'h501, 0, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    step(0, '0, '0, 1, 0, 0);
    // Reset with two entries queued.
    step(1, 64'h8000_0010, 32'h600, 0, 0, 0);
    step(1, 64'h8000_0014, 32'h601, 0, 0, 0);
    step(1, 64'h8000_0018, 32'h602, 1, 0, 1);
    step(0, '0, '0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pc = {$urandom, $urandom};
      if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
      step(logic'($urandom_range(99) < 60), pc, $urandom,
           logic'($urandom_range(99) < 55), logic'($urandom_range(99) < 5),
           logic'($urandom_range(99) < 2));
    end
    step(0, '0, '0, 1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
